// File: rtl/render_pkg.sv
// Shared types and raster constants for the frame scheduler and the top-level raster window.
package render_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARM       = 2'd1,
        ST_RENDER    = 2'd2,
        ST_DONE_WAIT = 2'd3
    } sched_state_t;

    localparam int DEF_SIZE     = 32;
    localparam int DEF_NUM_PINS = 10;
    localparam int DEF_TIMEOUT  = 2**20;

    // Raster window; END values are exclusive bounds.
    localparam int RASTER_START_X = 0;
    localparam int RASTER_START_Y = 0;
    localparam int RASTER_END_X   = 634;
    localparam int RASTER_END_Y   = 765;

endpackage

// File: rtl/render_watchdog.sv
// Loadable cycle counter with clear and enable; pulses expire_o while enabled at TIMEOUT-1.
module render_watchdog #(
    parameter int TIMEOUT = 2**20,
    localparam int CW     = $clog2(TIMEOUT)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          en_i,
    output logic          expire_o
);

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != LAST)) begin
            // Holds at LAST instead of wrapping.
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/render_frame_sched.sv
// Frame scheduler: scene shadow/snapshot, render start, last-pixel detect, watchdog and bank swap.
// Ping-pong banking is enabled by defining RENDER_SCHED_DOUBLE_BUFFER_EN.
module render_frame_sched
    import render_pkg::*;
#(
    parameter int SIZE     = DEF_SIZE,
    parameter int NUM_PINS = DEF_NUM_PINS,
    parameter int END_X    = RASTER_END_X,
    parameter int END_Y    = RASTER_END_Y,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     new_frame_in,
    input  logic                     scene_valid_in,
    input  logic [SIZE-1:0]          ball_x_in,
    input  logic [SIZE-1:0]          ball_y_in,
    input  logic [NUM_PINS*SIZE-1:0] pin_x_in,
    input  logic [NUM_PINS*SIZE-1:0] pin_y_in,
    input  logic                     px_valid_in,
    input  logic [10:0]              px_hcount_in,
    input  logic [9:0]               px_vcount_in,
    output logic                     gen_start_out,
    output logic [SIZE-1:0]          ball_x_out,
    output logic [SIZE-1:0]          ball_y_out,
    output logic [NUM_PINS*SIZE-1:0] pin_x_out,
    output logic [NUM_PINS*SIZE-1:0] pin_y_out,
    output logic                     wr_bank_out,
    output logic                     rd_bank_out,
    output logic                     busy_out,
    output logic                     timeout_out,
    output logic [7:0]               frames_dropped_out
);

    localparam int PW = NUM_PINS * SIZE;
    localparam int CW = $clog2(TIMEOUT);

    sched_state_t state_q, state_d;
    logic         gen_start_q, gen_start_d;
    logic         timeout_q, timeout_d;
    logic [7:0]   drops_q, drops_d;

    logic [SIZE-1:0] sh_ball_x_q, sh_ball_x_d, sh_ball_y_q, sh_ball_y_d;
    logic [PW-1:0]   sh_pin_x_q, sh_pin_x_d, sh_pin_y_q, sh_pin_y_d;
    logic [SIZE-1:0] sn_ball_x_q, sn_ball_x_d, sn_ball_y_q, sn_ball_y_d;
    logic [PW-1:0]   sn_pin_x_q, sn_pin_x_d, sn_pin_y_q, sn_pin_y_d;

    logic last_px;
    logic wd_expire;

    assign last_px = px_valid_in
                  && (px_hcount_in == 11'(END_X - 1))
                  && (px_vcount_in == 10'(END_Y - 1));

    render_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .clear_i    (state_q == ST_ARM),
        .load_i     (1'b0),
        .load_val_i ({CW{1'b0}}),
        .en_i       (state_q == ST_RENDER),
        .expire_o   (wd_expire)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        gen_start_d = 1'b0;
        timeout_d   = timeout_q;
        drops_d     = drops_q;

        sh_ball_x_d = scene_valid_in ? ball_x_in : sh_ball_x_q;
        sh_ball_y_d = scene_valid_in ? ball_y_in : sh_ball_y_q;
        sh_pin_x_d  = scene_valid_in ? pin_x_in  : sh_pin_x_q;
        sh_pin_y_d  = scene_valid_in ? pin_y_in  : sh_pin_y_q;

        sn_ball_x_d = sn_ball_x_q;
        sn_ball_y_d = sn_ball_y_q;
        sn_pin_x_d  = sn_pin_x_q;
        sn_pin_y_d  = sn_pin_y_q;

        case (state_q)
            ST_IDLE: begin
                if (new_frame_in) state_d = ST_ARM;
            end
            ST_ARM: begin
                // Copying from the shadow's next value gives the same-cycle bypass.
                sn_ball_x_d = sh_ball_x_d;
                sn_ball_y_d = sh_ball_y_d;
                sn_pin_x_d  = sh_pin_x_d;
                sn_pin_y_d  = sh_pin_y_d;
                gen_start_d = 1'b1;
                state_d     = ST_RENDER;
            end
            ST_RENDER: begin
                if (new_frame_in && (drops_q != 8'hFF)) drops_d = drops_q + 8'd1;
                if (last_px) begin
                    state_d = ST_DONE_WAIT;
                end else if (wd_expire) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DONE_WAIT: begin
                if (new_frame_in) state_d = ST_ARM;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the scene shadow is plain flops, not a RAM, so it is cleared by reset like any state.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            gen_start_q <= 1'b0;
            timeout_q   <= 1'b0;
            drops_q     <= 8'd0;
            sh_ball_x_q <= '0;
            sh_ball_y_q <= '0;
            sh_pin_x_q  <= '0;
            sh_pin_y_q  <= '0;
            sn_ball_x_q <= '0;
            sn_ball_y_q <= '0;
            sn_pin_x_q  <= '0;
            sn_pin_y_q  <= '0;
        end else begin
            state_q     <= state_d;
            gen_start_q <= gen_start_d;
            timeout_q   <= timeout_d;
            drops_q     <= drops_d;
            sh_ball_x_q <= sh_ball_x_d;
            sh_ball_y_q <= sh_ball_y_d;
            sh_pin_x_q  <= sh_pin_x_d;
            sh_pin_y_q  <= sh_pin_y_d;
            sn_ball_x_q <= sn_ball_x_d;
            sn_ball_y_q <= sn_ball_y_d;
            sn_pin_x_q  <= sn_pin_x_d;
            sn_pin_y_q  <= sn_pin_y_d;
        end
    end

`ifdef RENDER_SCHED_DOUBLE_BUFFER_EN
    // The swap is armed when leaving DONE_WAIT and lands with gen_start on the ARM exit edge.
    logic swap_pend_q, swap_pend_d;
    logic wr_bank_q, wr_bank_d;

    always_comb begin
        swap_pend_d = swap_pend_q;
        wr_bank_d   = wr_bank_q;
        if ((state_q == ST_DONE_WAIT) && new_frame_in) begin
            swap_pend_d = 1'b1;
        end else if (state_q == ST_ARM) begin
            swap_pend_d = 1'b0;
            if (swap_pend_q) wr_bank_d = ~wr_bank_q;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            swap_pend_q <= 1'b0;
            wr_bank_q   <= 1'b0;
        end else begin
            swap_pend_q <= swap_pend_d;
            wr_bank_q   <= wr_bank_d;
        end
    end

    assign wr_bank_out = wr_bank_q;
    assign rd_bank_out = ~wr_bank_q;
`else
    assign wr_bank_out = 1'b0;
    assign rd_bank_out = 1'b0;
`endif

    assign gen_start_out      = gen_start_q;
    assign timeout_out        = timeout_q;
    assign frames_dropped_out = drops_q;
    assign busy_out           = (state_q == ST_ARM) || (state_q == ST_RENDER);
    assign ball_x_out         = sn_ball_x_q;
    assign ball_y_out         = sn_ball_y_q;
    assign pin_x_out          = sn_pin_x_q;
    assign pin_y_out          = sn_pin_y_q;

endmodule

// File: tb/tb_render_frame_sched.sv
// Directed bench for render_frame_sched with a 64-cycle watchdog; bank expectations follow the build macro.
module tb_render_frame_sched;

    localparam int SZ  = 32;
    localparam int NP  = 10;
    localparam int PW  = NP * SZ;
`ifdef RENDER_SCHED_DOUBLE_BUFFER_EN
    localparam logic DB = 1'b1;
`else
    localparam logic DB = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          new_frame_in, scene_valid_in, px_valid_in;
    logic [SZ-1:0] ball_x_in, ball_y_in;
    logic [PW-1:0] pin_x_in, pin_y_in;
    logic [10:0]   px_hcount_in;
    logic [9:0]    px_vcount_in;
    logic          gen_start_out, wr_bank_out, rd_bank_out, busy_out, timeout_out;
    logic [SZ-1:0] ball_x_out, ball_y_out;
    logic [PW-1:0] pin_x_out, pin_y_out;
    logic [7:0]    frames_dropped_out;

    int total = 0;
    int bad   = 0;

    render_frame_sched #(
        .SIZE     (SZ),
        .NUM_PINS (NP),
        .END_X    (634),
        .END_Y    (765),
        .TIMEOUT  (64)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .new_frame_in       (new_frame_in),
        .scene_valid_in     (scene_valid_in),
        .ball_x_in          (ball_x_in),
        .ball_y_in          (ball_y_in),
        .pin_x_in           (pin_x_in),
        .pin_y_in           (pin_y_in),
        .px_valid_in        (px_valid_in),
        .px_hcount_in       (px_hcount_in),
        .px_vcount_in       (px_vcount_in),
        .gen_start_out      (gen_start_out),
        .ball_x_out         (ball_x_out),
        .ball_y_out         (ball_y_out),
        .pin_x_out          (pin_x_out),
        .pin_y_out          (pin_y_out),
        .wr_bank_out        (wr_bank_out),
        .rd_bank_out        (rd_bank_out),
        .busy_out           (busy_out),
        .timeout_out        (timeout_out),
        .frames_dropped_out (frames_dropped_out)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic last_pixel(input logic en);
        px_valid_in  = en;
        px_hcount_in = 11'd633;
        px_vcount_in = 10'd764;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gen_start"}, 32'(gen_start_out), 32'd0);
        check({tag, "_busy"},      32'(busy_out), 32'd0);
        check({tag, "_timeout"},   32'(timeout_out), 32'd0);
        check({tag, "_drops"},     32'(frames_dropped_out), 32'd0);
        check({tag, "_wr_bank"},   32'(wr_bank_out), 32'd0);
        check({tag, "_rd_bank"},   32'(rd_bank_out), 32'(DB));
        check({tag, "_ball_x"},    ball_x_out, 32'd0);
        check({tag, "_pin_x0"},    pin_x_out[31:0], 32'd0);
    endtask

    initial begin
        aresetn        = 1'b0;
        new_frame_in   = 1'b0;
        scene_valid_in = 1'b0;
        ball_x_in      = '0;
        ball_y_in      = '0;
        pin_x_in       = '0;
        pin_y_in       = '0;
        px_valid_in    = 1'b0;
        px_hcount_in   = '0;
        px_vcount_in   = '0;
        repeat (3) step();
        check_reset_outputs("rst");

        aresetn = 1'b1;
        step();

        // Load the shadow, then scramble the inputs so the snapshot must come from the shadow.
        scene_valid_in = 1'b1;
        ball_x_in      = 32'h3f80_0000;
        ball_y_in      = 32'h4000_0000;
        for (int i = 0; i < NP; i++) begin
            pin_x_in[i*SZ +: SZ] = 32'h4100_0000 + i;
            pin_y_in[i*SZ +: SZ] = 32'h4200_0000 + i;
        end
        step();
        scene_valid_in = 1'b0;
        ball_x_in      = 32'hdead_beef;
        ball_y_in      = '0;
        pin_x_in       = '0;
        pin_y_in       = '0;

        // First pass: ARM cycle, then one-cycle start pulse with snapshot.
        new_frame_in = 1'b1;
        step();
        new_frame_in = 1'b0;
        check("arm_busy", 32'(busy_out), 32'd1);
        check("arm_gen_start", 32'(gen_start_out), 32'd0);
        check("arm_ball_x_old", ball_x_out, 32'd0);
        step();
        check("p1_gen_start", 32'(gen_start_out), 32'd1);
        check("p1_busy", 32'(busy_out), 32'd1);
        check("p1_ball_x", ball_x_out, 32'h3f80_0000);
        check("p1_ball_y", ball_y_out, 32'h4000_0000);
        for (int i = 0; i < NP; i++) begin
            check("p1_pin_x", pin_x_out[i*SZ +: SZ], 32'h4100_0000 + i);
            check("p1_pin_y", pin_y_out[i*SZ +: SZ], 32'h4200_0000 + i);
        end
        check("p1_wr_bank", 32'(wr_bank_out), 32'd0);
        check("p1_rd_bank", 32'(rd_bank_out), 32'(DB));
        step();
        check("p1_gen_start_once", 32'(gen_start_out), 32'd0);

        // Scene update during RENDER must not disturb the snapshot.
        scene_valid_in = 1'b1;
        ball_x_in      = 32'h4310_0000;
        step();
        scene_valid_in = 1'b0;
        ball_x_in      = '0;
        step();
        check("render_snap_stable", ball_x_out, 32'h3f80_0000);

        repeat (3) begin
            new_frame_in = 1'b1;
            step();
            new_frame_in = 1'b0;
            step();
        end
        check("drops_3", 32'(frames_dropped_out), 32'd3);
        check("drops_still_busy", 32'(busy_out), 32'd1);

        // Near-miss pixels keep rendering.
        px_valid_in  = 1'b1;
        px_hcount_in = 11'd632;
        px_vcount_in = 10'd764;
        step();
        check("near_px_h", 32'(busy_out), 32'd1);
        px_hcount_in = 11'd633;
        px_vcount_in = 10'd763;
        step();
        check("near_px_v", 32'(busy_out), 32'd1);
        last_pixel(1'b0);
        step();
        check("px_not_valid", 32'(busy_out), 32'd1);
        last_pixel(1'b1);
        step();
        last_pixel(1'b0);
        check("last_px_busy", 32'(busy_out), 32'd0);
        step();
        check("done_wait_idle", 32'(gen_start_out), 32'd0);

        // Second pass: swap lands with gen_start, snapshot picks up the RENDER-time update.
        new_frame_in = 1'b1;
        step();
        new_frame_in = 1'b0;
        step();
        check("p2_gen_start", 32'(gen_start_out), 32'd1);
        check("p2_ball_x", ball_x_out, 32'h4310_0000);
        check("p2_wr_bank", 32'(wr_bank_out), 32'(DB));
        check("p2_rd_bank", 32'(rd_bank_out), 32'd0);
        check("p2_drops", 32'(frames_dropped_out), 32'd3);

        // Third pass: scene valid in the ARM cycle bypasses into the snapshot; banks toggle back.
        last_pixel(1'b1);
        step();
        last_pixel(1'b0);
        new_frame_in = 1'b1;
        step();
        new_frame_in   = 1'b0;
        scene_valid_in = 1'b1;
        ball_x_in      = 32'h4120_0000;
        step();
        scene_valid_in = 1'b0;
        ball_x_in      = '0;
        check("p3_gen_start", 32'(gen_start_out), 32'd1);
        check("p3_bypass_ball_x", ball_x_out, 32'h4120_0000);
        check("p3_wr_bank", 32'(wr_bank_out), 32'd0);
        check("p3_rd_bank", 32'(rd_bank_out), 32'(DB));

        // Last pixel and new_frame together: dropped, and no swap until the next new_frame.
        last_pixel(1'b1);
        new_frame_in = 1'b1;
        step();
        last_pixel(1'b0);
        new_frame_in = 1'b0;
        check("coinc_busy", 32'(busy_out), 32'd0);
        check("coinc_drops", 32'(frames_dropped_out), 32'd4);
        repeat (3) step();
        check("coinc_no_start", 32'(gen_start_out), 32'd0);
        check("coinc_no_swap", 32'(wr_bank_out), 32'd0);
        new_frame_in = 1'b1;
        step();
        new_frame_in = 1'b0;
        step();
        check("p4_gen_start", 32'(gen_start_out), 32'd1);
        check("p4_wr_bank", 32'(wr_bank_out), 32'(DB));
        check("p4_rd_bank", 32'(rd_bank_out), 32'd0);

        // Watchdog: this is RENDER cycle 1; expiry takes effect after cycle 64.
        repeat (63) step();
        check("wd_cycle64_timeout", 32'(timeout_out), 32'd0);
        check("wd_cycle64_busy", 32'(busy_out), 32'd1);
        step();
        check("wd_timeout", 32'(timeout_out), 32'd1);
        check("wd_idle", 32'(busy_out), 32'd0);
        check("wd_wr_bank", 32'(wr_bank_out), 32'(DB));
        check("wd_rd_bank", 32'(rd_bank_out), 32'd0);

        // Restart from IDLE: no swap, timeout stays sticky.
        new_frame_in = 1'b1;
        step();
        new_frame_in = 1'b0;
        step();
        check("restart_gen_start", 32'(gen_start_out), 32'd1);
        check("restart_timeout", 32'(timeout_out), 32'd1);
        check("restart_wr_bank", 32'(wr_bank_out), 32'(DB));

        // Continuous new_frame across several timed-out passes saturates the drop counter.
        new_frame_in = 1'b1;
        repeat (400) step();
        new_frame_in = 1'b0;
        check("drops_sat", 32'(frames_dropped_out), 32'd255);

        // Reset in the middle of RENDER.
        repeat (70) step();
        new_frame_in = 1'b1;
        step();
        new_frame_in = 1'b0;
        repeat (3) step();
        check("pre_rst_busy", 32'(busy_out), 32'd1);
        aresetn = 1'b0;
        step();
        check_reset_outputs("midrst");
        aresetn = 1'b1;
        step();
        new_frame_in = 1'b1;
        step();
        new_frame_in = 1'b0;
        step();
        check("post_rst_gen_start", 32'(gen_start_out), 32'd1);
        check("post_rst_wr_bank", 32'(wr_bank_out), 32'd0);
        check("post_rst_rd_bank", 32'(rd_bank_out), 32'(DB));
        check("post_rst_ball_x", ball_x_out, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
